// File: rtl/cpu_defs.sv
// Shared CPU definitions: control-sequencer state encodings and opcode constants,
// also used by the datapath.
package cpu_defs;

  typedef enum logic [7:0] {
    RESET_ST = 8'd0,
    T0       = 8'd1,
    T1       = 8'd2,
    T2       = 8'd3,
    ALU_T3   = 8'd4,
    ALU_T4   = 8'd5,
    ALU_T5   = 8'd6,
    IMM_T3   = 8'd7,
    IMM_T4   = 8'd8,
    IMM_T5   = 8'd9,
    LD_T3    = 8'd10,
    LD_T4    = 8'd11,
    LD_T5    = 8'd12,
    LD_T6    = 8'd13,
    LD_T7    = 8'd14,
    ST_T3    = 8'd15,
    ST_T4    = 8'd16,
    ST_T5    = 8'd17,
    ST_T6    = 8'd18,
    ST_T7    = 8'd19,
    BR_T3    = 8'd20,
    BR_T4    = 8'd21,
    BR_T5    = 8'd22,
    BR_T6    = 8'd23,
    HALT     = 8'd255
  } state_t;

  localparam logic [4:0] OP_LD        = 5'b00000;
  localparam logic [4:0] OP_ST        = 5'b00010;
  localparam logic [4:0] OP_ADD       = 5'b00011;
  localparam logic [4:0] OP_ALU_LAST  = 5'b01011;
  localparam logic [4:0] OP_IMM_FIRST = 5'b01100;
  localparam logic [4:0] OP_IMM_LAST  = 5'b01110;
  localparam logic [4:0] OP_BR        = 5'b10011;
  localparam logic [4:0] OP_NOP       = 5'b11010;
  localparam logic [4:0] OP_HALT      = 5'b11011;

endpackage

// File: rtl/control_sequencer.sv
// Moore control sequencer: fetch, dispatch on IR[31:27] and per-class micro-sequences.
module control_sequencer
  import cpu_defs::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  input  logic        stop,
  output logic [7:0]  present_state,
  output logic        run,
  output logic        PC_out,
  output logic        MAR_in,
  output logic        inc_PC,
  output logic        Z_in,
  output logic        ZLO_out,
  output logic        PC_in,
  output logic        MEM_rd_en,
  output logic        MEM_wr_en,
  output logic        MDR_in,
  output logic        MDR_out,
  output logic        IR_in,
  output logic        Y_in,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        R_in,
  output logic        R_out,
  output logic        BA_out,
  output logic        C_sign_out,
  output logic        CON_in,
  output logic [4:0]  alu_op
);

  state_t state, nxt;
  logic [4:0] opc;

  assign opc           = IR[31:27];
  assign present_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RESET_ST;
    else        state <= nxt;
  end

  always_comb begin
    nxt        = state;
    run        = 1'b1;
    PC_out     = 1'b0;  MAR_in    = 1'b0;  inc_PC    = 1'b0;  Z_in    = 1'b0;
    ZLO_out    = 1'b0;  PC_in     = 1'b0;  MEM_rd_en = 1'b0;  MEM_wr_en = 1'b0;
    MDR_in     = 1'b0;  MDR_out   = 1'b0;  IR_in     = 1'b0;  Y_in    = 1'b0;
    Gra        = 1'b0;  Grb       = 1'b0;  Grc       = 1'b0;  R_in    = 1'b0;
    R_out      = 1'b0;  BA_out    = 1'b0;  C_sign_out = 1'b0; CON_in  = 1'b0;
    alu_op     = OP_ADD;
    case (state)
      RESET_ST: begin run = 1'b0; nxt = T0; end
      T0: begin
        PC_out = 1'b1; MAR_in = 1'b1; inc_PC = 1'b1; Z_in = 1'b1;
        nxt = stop ? HALT : T1;
      end
      T1: begin ZLO_out = 1'b1; PC_in = 1'b1; MEM_rd_en = 1'b1; MDR_in = 1'b1; nxt = T2; end
      T2: begin
        MDR_out = 1'b1; IR_in = 1'b1;
        if (opc >= OP_ADD && opc <= OP_ALU_LAST)            nxt = ALU_T3;
        else if (opc >= OP_IMM_FIRST && opc <= OP_IMM_LAST) nxt = IMM_T3;
        else if (opc == OP_LD)                              nxt = LD_T3;
        else if (opc == OP_ST)                              nxt = ST_T3;
        else if (opc == OP_BR)                              nxt = BR_T3;
        else if (opc == OP_HALT)                            nxt = HALT;
        else                                                nxt = T0;
      end
      ALU_T3: begin Grb = 1'b1; R_out = 1'b1; Y_in = 1'b1; nxt = ALU_T4; end
      ALU_T4: begin Grc = 1'b1; R_out = 1'b1; Z_in = 1'b1; alu_op = opc; nxt = ALU_T5; end
      ALU_T5: begin ZLO_out = 1'b1; Gra = 1'b1; R_in = 1'b1; nxt = T0; end
      IMM_T3: begin Grb = 1'b1; R_out = 1'b1; Y_in = 1'b1; nxt = IMM_T4; end
      IMM_T4: begin C_sign_out = 1'b1; Z_in = 1'b1; alu_op = opc; nxt = IMM_T5; end
      IMM_T5: begin ZLO_out = 1'b1; Gra = 1'b1; R_in = 1'b1; nxt = T0; end
      LD_T3:  begin Grb = 1'b1; BA_out = 1'b1; Y_in = 1'b1; nxt = LD_T4; end
      LD_T4:  begin C_sign_out = 1'b1; Z_in = 1'b1; nxt = LD_T5; end
      LD_T5:  begin ZLO_out = 1'b1; MAR_in = 1'b1; nxt = LD_T6; end
      LD_T6:  begin MEM_rd_en = 1'b1; MDR_in = 1'b1; nxt = LD_T7; end
      LD_T7:  begin MDR_out = 1'b1; Gra = 1'b1; R_in = 1'b1; nxt = T0; end
      ST_T3:  begin Grb = 1'b1; BA_out = 1'b1; Y_in = 1'b1; nxt = ST_T4; end
      ST_T4:  begin C_sign_out = 1'b1; Z_in = 1'b1; nxt = ST_T5; end
      ST_T5:  begin ZLO_out = 1'b1; MAR_in = 1'b1; nxt = ST_T6; end
      ST_T6:  begin Gra = 1'b1; R_out = 1'b1; MDR_in = 1'b1; nxt = ST_T7; end
      ST_T7:  begin MEM_wr_en = 1'b1; nxt = T0; end
      BR_T3:  begin Gra = 1'b1; R_out = 1'b1; CON_in = 1'b1; nxt = BR_T4; end
      BR_T4:  begin PC_out = 1'b1; Y_in = 1'b1; nxt = BR_T5; end
      BR_T5:  begin C_sign_out = 1'b1; Z_in = 1'b1; nxt = BR_T6; end
      // Branch is taken by loading the computed target only when the flag is set.
      BR_T6:  begin ZLO_out = 1'b1; PC_in = CON_FF; nxt = T0; end
      HALT:   begin run = 1'b0; nxt = HALT; end
      default: begin run = 1'b0; nxt = RESET_ST; end
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer: per-instruction expected state walks
// built from opcode classes, control sets checked against the micro-op table.
module tb_control_sequencer;
  import cpu_defs::*;

  logic clk = 1'b0, rst_n = 1'b0, CON_FF = 1'b0, stop = 1'b0;
  logic [31:0] IR = '0;
  logic [7:0] present_state;
  logic [4:0] alu_op;
  logic run, PC_out, MAR_in, inc_PC, Z_in, ZLO_out, PC_in, MEM_rd_en, MEM_wr_en,
        MDR_in, MDR_out, IR_in, Y_in, Gra, Grb, Grc, R_in, R_out, BA_out, C_sign_out, CON_in;

  control_sequencer dut (
    .clk(clk), .rst_n(rst_n), .IR(IR), .CON_FF(CON_FF), .stop(stop),
    .present_state(present_state), .run(run), .PC_out(PC_out), .MAR_in(MAR_in),
    .inc_PC(inc_PC), .Z_in(Z_in), .ZLO_out(ZLO_out), .PC_in(PC_in), .MEM_rd_en(MEM_rd_en),
    .MEM_wr_en(MEM_wr_en), .MDR_in(MDR_in), .MDR_out(MDR_out), .IR_in(IR_in), .Y_in(Y_in),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .R_in(R_in), .R_out(R_out), .BA_out(BA_out),
    .C_sign_out(C_sign_out), .CON_in(CON_in), .alu_op(alu_op)
  );

  always #5 clk = ~clk;

  localparam int PCO = 19, MAR = 18, INC = 17, ZI = 16, ZLO = 15, PCI = 14, RD = 13, WR = 12,
                 MDI = 11, MDO = 10, IRI = 9, YI = 8, GA = 7, GB = 6, GC = 5, RI = 4,
                 RO = 3, BA = 2, CS = 1, CI = 0;

  logic [19:0] ctl;
  assign ctl = {PC_out, MAR_in, inc_PC, Z_in, ZLO_out, PC_in, MEM_rd_en, MEM_wr_en, MDR_in,
                MDR_out, IR_in, Y_in, Gra, Grb, Grc, R_in, R_out, BA_out, C_sign_out, CON_in};

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Control set each state is documented to assert.
  function automatic logic [19:0] exp_ctl(state_t s, logic con);
    logic [19:0] m = '0;
    case (s)
      T0:     begin m[PCO] = 1; m[MAR] = 1; m[INC] = 1; m[ZI] = 1; end
      T1:     begin m[ZLO] = 1; m[PCI] = 1; m[RD] = 1; m[MDI] = 1; end
      T2:     begin m[MDO] = 1; m[IRI] = 1; end
      ALU_T3, IMM_T3: begin m[GB] = 1; m[RO] = 1; m[YI] = 1; end
      ALU_T4: begin m[GC] = 1; m[RO] = 1; m[ZI] = 1; end
      IMM_T4, LD_T4, ST_T4, BR_T5: begin m[CS] = 1; m[ZI] = 1; end
      ALU_T5, IMM_T5: begin m[ZLO] = 1; m[GA] = 1; m[RI] = 1; end
      LD_T3, ST_T3: begin m[GB] = 1; m[BA] = 1; m[YI] = 1; end
      LD_T5, ST_T5: begin m[ZLO] = 1; m[MAR] = 1; end
      LD_T6:  begin m[RD] = 1; m[MDI] = 1; end
      LD_T7:  begin m[MDO] = 1; m[GA] = 1; m[RI] = 1; end
      ST_T6:  begin m[GA] = 1; m[RO] = 1; m[MDI] = 1; end
      ST_T7:  m[WR] = 1;
      BR_T3:  begin m[GA] = 1; m[RO] = 1; m[CI] = 1; end
      BR_T4:  begin m[PCO] = 1; m[YI] = 1; end
      BR_T6:  begin m[ZLO] = 1; m[PCI] = con; end
      default: m = '0;
    endcase
    return m;
  endfunction

  task automatic check_cycle(input state_t s, input string tag);
    chk($sformatf("%s/%s/state", tag, s.name()), 32'(present_state), 32'(s));
    chk($sformatf("%s/%s/ctl", tag, s.name()), 32'(ctl), 32'(exp_ctl(s, CON_FF)));
    chk($sformatf("%s/%s/alu_op", tag, s.name()), 32'(alu_op),
        (s == ALU_T4 || s == IMM_T4) ? 32'(IR[31:27]) : 32'(OP_ADD));
    chk($sformatf("%s/%s/run", tag, s.name()), 32'(run), 32'(s != RESET_ST && s != HALT));
  endtask

  // Called mid-cycle with rst_n low; returns at a falling edge sitting in T0.
  task automatic release_reset();
    stop = 1'b0;
    @(negedge clk);
    check_cycle(RESET_ST, "rst_hold");
    rst_n = 1'b1;
    @(negedge clk);
    check_cycle(T0, "rst_exit");
  endtask

  task automatic run_instr(input logic [31:0] ir, input int con, input bit stp, input int abort_idx);
    state_t q[$];
    logic [4:0] opc = ir[31:27];
    int wr = 0, rd = 0;
    q.push_back(T0);
    if (stp) q.push_back(HALT);
    else begin
      q.push_back(T1); q.push_back(T2);
      if (opc >= 5'd3 && opc <= 5'd11)       q = {q, ALU_T3, ALU_T4, ALU_T5, T0};
      else if (opc >= 5'd12 && opc <= 5'd14) q = {q, IMM_T3, IMM_T4, IMM_T5, T0};
      else if (opc == 5'd0)                  q = {q, LD_T3, LD_T4, LD_T5, LD_T6, LD_T7, T0};
      else if (opc == 5'd2)                  q = {q, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, T0};
      else if (opc == 5'd19)                 q = {q, BR_T3, BR_T4, BR_T5, BR_T6, T0};
      else if (opc == 5'd27)                 q.push_back(HALT);
      else                                   q.push_back(T0);
    end
    IR = ir;
    stop = stp;
    CON_FF = (con == 2) ? 1'($urandom) : 1'(con);
    for (int i = 0; i < q.size(); i++) begin
      if (i > 0) @(negedge clk);
      if (i == abort_idx) begin
        #2 rst_n = 1'b0;
        #1;
        chk("abort/state", 32'(present_state), 32'(RESET_ST));
        chk("abort/ctl", 32'(ctl), 32'd0);
        chk("abort/run", 32'(run), 32'd0);
        chk("abort/alu_op", 32'(alu_op), 32'(OP_ADD));
        release_reset();
        chk("abort/wr_seen", 32'(wr), 32'd0);
        return;
      end
      check_cycle(q[i], "seq");
      wr += int'(MEM_wr_en);
      rd += int'(MEM_rd_en);
      // stop only matters on the T0 edge, so scramble it everywhere else.
      if (q[i] != T0) stop = 1'($urandom);
      if (con == 2) CON_FF = 1'($urandom);
    end
    chk($sformatf("wr_cnt/op%0d", opc), 32'(wr), 32'(!stp && opc == OP_ST));
    chk($sformatf("rd_cnt/op%0d", opc), 32'(rd), stp ? 32'd0 : (opc == OP_LD ? 32'd2 : 32'd1));
    if (q[q.size()-1] == HALT) begin
      repeat (20) begin
        stop = 1'($urandom);
        CON_FF = 1'($urandom);
        @(negedge clk);
        check_cycle(HALT, "hold");
      end
      rst_n = 1'b0;
      #1 check_cycle(RESET_ST, "rst_async");
      release_reset();
    end
  endtask

  initial begin
    #1 check_cycle(RESET_ST, "por");
    #2 check_cycle(RESET_ST, "por2");
    release_reset();

    run_instr(32'h1A2B8000, 2, 1'b0, -1);
    run_instr({OP_LD, 27'($urandom)}, 2, 1'b0, -1);
    run_instr({OP_ST, 27'($urandom)}, 2, 1'b0, -1);
    run_instr({OP_BR, 27'($urandom)}, 1, 1'b0, -1);
    run_instr({OP_BR, 27'($urandom)}, 0, 1'b0, -1);
    run_instr({5'b01101, 27'($urandom)}, 2, 1'b0, -1);
    run_instr({OP_NOP, 27'($urandom)}, 2, 1'b0, -1);
    run_instr({5'b11111, 27'($urandom)}, 2, 1'b0, -1);
    run_instr({OP_HALT, 27'($urandom)}, 2, 1'b0, -1);
    run_instr({OP_ADD, 27'($urandom)}, 2, 1'b1, -1);
    run_instr({OP_LD, 27'($urandom)}, 2, 1'b0, 5);
    run_instr({OP_ST, 27'($urandom)}, 2, 1'b0, 7);

    for (int k = 0; k < 120; k++)
      run_instr({5'($urandom_range(0, 31)), 27'($urandom)}, 2,
                $urandom_range(0, 7) == 0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
